// File: rtl/fetch_decode_queue_if.sv
// rtl/fetch_decode_queue_if.sv - fetch/decode handshake bundle for the instruction queue
//
// Purpose: groups every non-clock, non-reset signal between fetch, the queue and decode.
// Ports (signals):
//   flush, earlyMisdirect              pipeline kill requests (commit mispredict, decode JAL)
//   fetchValid, instr, instrPC,
//   predictedPCF, GHRIndex, PHTState,
//   redirect                           fetch output register contents
//   freeze                             back-pressure to fetch
//   decodeReady                        decode accepts the head entry
//   decodeValid, dec*                  head entry presented to decode
//   occupancy                          entries currently held
// Modports: master = fetch/decode side, slave = queue side.
interface fetch_decode_queue_if #(
  parameter int WIDTH = 31,
  parameter int INDEX = 7,
  parameter int PTR   = 2
);
  logic             flush;
  logic             earlyMisdirect;
  logic             fetchValid;
  logic [WIDTH:0]   instr;
  logic [WIDTH:0]   instrPC;
  logic [WIDTH:0]   predictedPCF;
  logic [INDEX:0]   GHRIndex;
  logic [1:0]       PHTState;
  logic             redirect;
  logic             freeze;
  logic             decodeReady;
  logic             decodeValid;
  logic [WIDTH:0]   decInstr;
  logic [WIDTH:0]   decPC;
  logic [WIDTH:0]   decPredictedPC;
  logic [INDEX:0]   decGHRIndex;
  logic [1:0]       decPHTState;
  logic             decRedirect;
  logic [PTR:0]     occupancy;

  modport master (
    output flush, earlyMisdirect, fetchValid, instr, instrPC, predictedPCF,
           GHRIndex, PHTState, redirect, decodeReady,
    input  freeze, decodeValid, decInstr, decPC, decPredictedPC, decGHRIndex,
           decPHTState, decRedirect, occupancy
  );

  modport slave (
    input  flush, earlyMisdirect, fetchValid, instr, instrPC, predictedPCF,
           GHRIndex, PHTState, redirect, decodeReady,
    output freeze, decodeValid, decInstr, decPC, decPredictedPC, decGHRIndex,
           decPHTState, decRedirect, occupancy
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - in-order instruction queue between fetch and decode
//
// Purpose: buffers fetched instructions with their prediction metadata, back-pressures
// fetch with freeze when full, presents the oldest entry to decode, and empties on
// commit misprediction or decode-stage JAL redirect.
// Ports:
//   clk          clock, all state updates on posedge
//   globalReset  synchronous active-high reset
//   bus          fetch_decode_queue_if.slave (fetch inputs, freeze, decode handshake, occupancy)
module fetch_decode_queue #(
  parameter int WIDTH = 31,
  parameter int INDEX = 7,
  parameter int DEPTH = 4,
  parameter int PTR   = 2
) (
  input  logic                 clk,
  input  logic                 globalReset,
  fetch_decode_queue_if.slave  bus
);

  localparam logic [PTR:0]   CNT_FULL = (PTR+1)'(DEPTH);
  localparam logic [PTR:0]   CNT_ONE  = (PTR+1)'(1);
  localparam logic [PTR-1:0] PTR_ONE  = PTR'(1);

  typedef struct packed {
    logic [WIDTH:0] instr;
    logic [WIDTH:0] pc;
    logic [WIDTH:0] predicted_pc;
    logic [INDEX:0] ghr_index;
    logic [1:0]     pht_state;
    logic           redirect;
  } entry_t;

  entry_t         mem [DEPTH];
  entry_t         wr_entry;
  entry_t         head_entry;

  logic [PTR-1:0] head;
  logic [PTR-1:0] tail;
  logic [PTR:0]   count;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic kill;

  // freeze depends on registered count only, so fetch never sees a
  // combinational path from decodeReady; a pop while full does not
  // admit a push in the same cycle, the slot refills one cycle later.
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign push  = bus.fetchValid & ~full;
  assign pop   = ~empty & bus.decodeReady;
  assign kill  = bus.flush | bus.earlyMisdirect;

  assign wr_entry = '{
    instr:        bus.instr,
    pc:           bus.instrPC,
    predicted_pc: bus.predictedPCF,
    ghr_index:    bus.GHRIndex,
    pht_state:    bus.PHTState,
    redirect:     bus.redirect
  };

  // Pointer and count state. A kill drops everything including a same-cycle
  // push; a same-cycle pop is already consumed by decode so nothing is lost.
  always_ff @(posedge clk) begin
    if (globalReset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (kill) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; validity is carried entirely by count.
  always_ff @(posedge clk) begin
    if (push && !kill && !globalReset) begin
      mem[tail] <= wr_entry;
    end
  end

  assign head_entry = mem[head];

  // Head is read combinationally; everything reads as zero while empty.
  always_comb begin
    bus.decodeValid    = 1'b0;
    bus.decInstr       = '0;
    bus.decPC          = '0;
    bus.decPredictedPC = '0;
    bus.decGHRIndex    = '0;
    bus.decPHTState    = '0;
    bus.decRedirect    = 1'b0;
    if (!empty) begin
      bus.decodeValid    = 1'b1;
      bus.decInstr       = head_entry.instr;
      bus.decPC          = head_entry.pc;
      bus.decPredictedPC = head_entry.predicted_pc;
      bus.decGHRIndex    = head_entry.ghr_index;
      bus.decPHTState    = head_entry.pht_state;
      bus.decRedirect    = head_entry.redirect;
    end
  end

  assign bus.freeze    = full;
  assign bus.occupancy = count;

endmodule
